// File: rtl/mem_port_arbiter.sv
// Arbiter for the single-ported unified memory shared by instruction fetch
// and data access. Each pending access runs as one valid/ready bus
// transaction; data goes first, then fetch. The pipeline is stalled until
// every access needed by the current instruction has completed. A wait
// counter forces completion (read data 0, sticky bus_err) on a hung bus.
module mem_port_arbiter #(
  parameter int TIMEOUT = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        stall,
  output logic [31:0] mem_rdata,
  output logic [31:0] if_rdata,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic        bus_ready,
  input  logic [31:0] bus_rdata,
  output logic        bus_err
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DATA  = 2'd1,
    FETCH = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic          data_ok_q, data_ok_d;
  logic          fetch_ok_q, fetch_ok_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          bus_we_q, bus_we_d;
  logic [31:0]   bus_addr_q, bus_addr_d;
  logic [31:0]   bus_wdata_q, bus_wdata_d;
  logic [31:0]   mem_rdata_q, mem_rdata_d;
  logic [31:0]   if_rdata_q, if_rdata_d;
  logic          bus_err_q, bus_err_d;

  logic data_need;
  logic fetch_need;
  logic data_pend;
  logic fetch_pend;
  logic bus_done;
  logic timeout_hit;

  // Next-state, bus setup, result capture and stall generation.
  always_comb begin
    state_d     = state_q;
    data_ok_d   = data_ok_q;
    fetch_ok_d  = fetch_ok_q;
    cnt_d       = cnt_q;
    bus_we_d    = bus_we_q;
    bus_addr_d  = bus_addr_q;
    bus_wdata_d = bus_wdata_q;
    mem_rdata_d = mem_rdata_q;
    if_rdata_d  = if_rdata_q;
    bus_err_d   = bus_err_q;

    data_need  = mem_read | mem_write;
    fetch_need = if_req;
    data_pend  = data_need & ~data_ok_q;
    fetch_pend = fetch_need & ~fetch_ok_q;

    // The pipeline may advance only once every needed access is done.
    stall = reset & ~((~data_need | data_ok_q) & (~fetch_need | fetch_ok_q));

    // Last allowed wait cycle: completion is forced if the bus is still busy.
    timeout_hit = ~bus_ready & (cnt_q == CNT_LAST);
    bus_done    = bus_ready | (cnt_q == CNT_LAST);

    case (state_q)
      IDLE: begin
        if (data_pend) begin
          state_d     = DATA;
          bus_addr_d  = mem_addr;
          bus_we_d    = mem_write;
          bus_wdata_d = mem_wdata;
          cnt_d       = '0;
        end else if (fetch_pend) begin
          state_d    = FETCH;
          bus_addr_d = if_addr;
          bus_we_d   = 1'b0;
          cnt_d      = '0;
        end
      end

      DATA: begin
        if (bus_done) begin
          if (!bus_we_q) begin
            mem_rdata_d = timeout_hit ? 32'h0 : bus_rdata;
          end
          data_ok_d = 1'b1;
          bus_err_d = bus_err_q | timeout_hit;
          // Chain straight into the fetch so no idle cycle is wasted.
          if (fetch_pend) begin
            state_d    = FETCH;
            bus_addr_d = if_addr;
            bus_we_d   = 1'b0;
            cnt_d      = '0;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      FETCH: begin
        if (bus_done) begin
          if_rdata_d = timeout_hit ? 32'h0 : bus_rdata;
          fetch_ok_d = 1'b1;
          bus_err_d  = bus_err_q | timeout_hit;
          state_d    = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase

    // The pipeline advances at this edge, so the next instruction starts fresh.
    if (!stall) begin
      data_ok_d  = 1'b0;
      fetch_ok_d = 1'b0;
    end
  end

  // State and datapath registers, cleared asynchronously while reset is low.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      data_ok_q   <= 1'b0;
      fetch_ok_q  <= 1'b0;
      cnt_q       <= '0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= 32'h0;
      bus_wdata_q <= 32'h0;
      mem_rdata_q <= 32'h0;
      if_rdata_q  <= 32'h0;
      bus_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      data_ok_q   <= data_ok_d;
      fetch_ok_q  <= fetch_ok_d;
      cnt_q       <= cnt_d;
      bus_we_q    <= bus_we_d;
      bus_addr_q  <= bus_addr_d;
      bus_wdata_q <= bus_wdata_d;
      mem_rdata_q <= mem_rdata_d;
      if_rdata_q  <= if_rdata_d;
      bus_err_q   <= bus_err_d;
    end
  end

  assign bus_req   = (state_q == DATA) | (state_q == FETCH);
  assign bus_we    = bus_we_q;
  assign bus_addr  = bus_addr_q;
  assign bus_wdata = bus_wdata_q;
  assign mem_rdata = mem_rdata_q;
  assign if_rdata  = if_rdata_q;
  assign bus_err   = bus_err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios followed by random
// instructions, checked against a per-instruction cost/result model and a
// memory model kept in an associative array.
module tb_mem_port_arbiter;

  localparam int TIMEOUT = 16;
  localparam int NEVER   = 1000;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        mem_read = 1'b0;
  logic        mem_write = 1'b0;
  logic [31:0] mem_addr = 32'h0;
  logic [31:0] mem_wdata = 32'h0;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = 32'h0;
  logic        stall;
  logic [31:0] mem_rdata;
  logic [31:0] if_rdata;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic        bus_ready = 1'b0;
  logic [31:0] bus_rdata = 32'h0;
  logic        bus_err;

  mem_port_arbiter #(.TIMEOUT(TIMEOUT)) dut (
    .clock     (clock),
    .reset     (reset),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .stall     (stall),
    .mem_rdata (mem_rdata),
    .if_rdata  (if_rdata),
    .bus_req   (bus_req),
    .bus_we    (bus_we),
    .bus_addr  (bus_addr),
    .bus_wdata (bus_wdata),
    .bus_ready (bus_ready),
    .bus_rdata (bus_rdata),
    .bus_err   (bus_err)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
    int          w;      // wait states before ready; >= TIMEOUT means never
  } txn_t;

  int          checks = 0;
  int          errors = 0;
  txn_t        exp_q[$];
  logic [31:0] mem_m [logic [31:0]];
  logic [31:0] exp_mem_rdata = 32'h0;
  logic [31:0] exp_if_rdata  = 32'h0;
  logic        exp_err       = 1'b0;
  bit          in_txn        = 1'b0;
  int          tc            = 0;
  txn_t        cur;

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (mem_m.exists(a)) return mem_m[a];
    return (a * 32'h9E3779B1) ^ 32'h13579BDF;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    end
  endtask

  // One instruction: plan the expected bus transactions and results, serve
  // the bus cycle by cycle until stall drops, then let the pipeline advance.
  task automatic run_instr(input int op, input logic [31:0] a, input logic [31:0] wd,
                           input bit f, input logic [31:0] pc,
                           input int wdw, input int wfw, input string tag);
    int   n = 0;
    int   exp_stall = 1;
    int   stalls = 0;
    bit   rdy_now;
    bit   req_now;
    bit   done_now;
    txn_t t;

    mem_read  = (op == 1);
    mem_write = (op == 2);
    mem_addr  = a;
    mem_wdata = wd;
    if_req    = f;
    if_addr   = pc;

    if (op != 0) begin
      t.addr = a; t.we = (op == 2); t.wdata = wd; t.w = wdw;
      exp_q.push_back(t);
      n++;
      exp_stall += (wdw >= TIMEOUT) ? TIMEOUT : wdw + 1;
      if (wdw >= TIMEOUT) exp_err = 1'b1;
      if (op == 1) exp_mem_rdata = (wdw >= TIMEOUT) ? 32'h0 : mem_rd(a);
      if (op == 2 && wdw < TIMEOUT) mem_m[a] = wd;
    end
    if (f) begin
      t.addr = pc; t.we = 1'b0; t.wdata = 32'h0; t.w = wfw;
      exp_q.push_back(t);
      n++;
      exp_stall += (wfw >= TIMEOUT) ? TIMEOUT : wfw + 1;
      if (wfw >= TIMEOUT) exp_err = 1'b1;
      exp_if_rdata = (wfw >= TIMEOUT) ? 32'h0 : mem_rd(pc);
    end
    if (n == 0) exp_stall = 0;

    #1;
    while (stall === 1'b1 && stalls < 200) begin
      stalls++;
      req_now = bus_req;
      rdy_now = 1'b0;
      if (req_now) begin
        if (!in_txn) begin
          in_txn = 1'b1;
          tc = 0;
          if (exp_q.size() == 0) begin
            check({tag, "_extra_txn"}, 32'd1, 32'd0);
            cur.addr = bus_addr; cur.we = bus_we; cur.wdata = bus_wdata; cur.w = 0;
          end else begin
            cur = exp_q.pop_front();
          end
        end
        check({tag, "_bus_addr"}, bus_addr, cur.addr);
        check({tag, "_bus_we"}, {31'h0, bus_we}, {31'h0, cur.we});
        if (cur.we) check({tag, "_bus_wdata"}, bus_wdata, cur.wdata);
        rdy_now   = (tc == cur.w);
        bus_ready = rdy_now;
        bus_rdata = (rdy_now && !cur.we) ? mem_rd(cur.addr) : $urandom;
      end else begin
        bus_ready = 1'($urandom_range(0, 1));
        bus_rdata = $urandom;
      end
      done_now = req_now && (rdy_now || tc == TIMEOUT - 1);
      @(posedge clock);
      #1;
      if (done_now) in_txn = 1'b0;
      else if (req_now) tc++;
      bus_ready = 1'b0;
      #1;
    end

    check({tag, "_stall_cycles"}, stalls, exp_stall);
    check({tag, "_bus_req_idle"}, {31'h0, bus_req}, 32'h0);
    check({tag, "_mem_rdata"}, mem_rdata, exp_mem_rdata);
    check({tag, "_if_rdata"}, if_rdata, exp_if_rdata);
    check({tag, "_bus_err"}, {31'h0, bus_err}, {31'h0, exp_err});
    check({tag, "_pending_txn"}, exp_q.size(), 32'd0);
    $display("instr %s: op=%0d addr=%h fetch=%0d pc=%h stalls=%0d", tag, op, a, f, pc, stalls);
    exp_q.delete();
    in_txn = 1'b0;

    @(posedge clock);
    #1;
  endtask

  initial begin
    int op;
    bit f;
    int wd_w;
    int wf_w;

    // Reset held low: everything cleared, no stall even with a pending need.
    mem_read = 1'b1;
    #12;
    check("rst_stall", {31'h0, stall}, 32'h0);
    check("rst_bus_req", {31'h0, bus_req}, 32'h0);
    check("rst_bus_addr", bus_addr, 32'h0);
    check("rst_mem_rdata", mem_rdata, 32'h0);
    check("rst_bus_err", {31'h0, bus_err}, 32'h0);
    mem_read = 1'b0;
    @(posedge clock);
    #1;
    reset = 1'b1;

    mem_m[32'h40]  = 32'hDEADBEEF;
    mem_m[32'h100] = 32'hCAFE0100;
    mem_m[32'h200] = 32'hBEEF0200;
    run_instr(0, 32'h0,   32'h0,        1'b0, 32'h0,   0, 0, "no_need");
    run_instr(1, 32'h40,  32'h0,        1'b0, 32'h0,   0, 0, "load_zw");
    run_instr(2, 32'h80,  32'h12345678, 1'b0, 32'h0,   2, 0, "store_w2");
    run_instr(1, 32'h200, 32'h0,        1'b1, 32'h100, 0, 0, "load_fetch");
    run_instr(0, 32'h0,   32'h0,        1'b1, 32'h0,   0, 0, "fetch_pc0");
    run_instr(0, 32'h0,   32'h0,        1'b1, 32'h4,   0, 0, "fetch_pc4");
    run_instr(0, 32'h0,   32'h0,        1'b1, 32'h8,   0, 0, "fetch_pc8");
    run_instr(0, 32'h0,   32'h0,        1'b1, 32'h300, 0, NEVER, "fetch_tmo");
    run_instr(1, 32'h80,  32'h0,        1'b0, 32'h0,   1, 0, "load_back");

    for (int i = 0; i < 150; i++) begin
      op   = $urandom_range(0, 2);
      f    = ($urandom_range(0, 3) != 0);
      wd_w = ($urandom_range(0, 11) == 0) ? NEVER : $urandom_range(0, 3);
      wf_w = ($urandom_range(0, 11) == 0) ? NEVER : $urandom_range(0, 3);
      run_instr(op, {$urandom_range(0, 63), 2'b00}, $urandom, f,
                {$urandom_range(0, 63), 2'b00}, wd_w, wf_w, $sformatf("rnd%0d", i));
    end

    // Reset in the second wait cycle of a data access.
    mem_read  = 1'b1;
    mem_write = 1'b0;
    mem_addr  = 32'h40;
    if_req    = 1'b0;
    bus_ready = 1'b0;
    @(posedge clock);
    #1;
    @(posedge clock);
    #1;
    check("midrst_bus_req_before", {31'h0, bus_req}, 32'h1);
    check("midrst_bus_err_before", {31'h0, bus_err}, 32'h1);
    reset = 1'b0;
    #1;
    check("midrst_bus_req", {31'h0, bus_req}, 32'h0);
    check("midrst_stall", {31'h0, stall}, 32'h0);
    check("midrst_bus_err", {31'h0, bus_err}, 32'h0);
    check("midrst_bus_we", {31'h0, bus_we}, 32'h0);
    check("midrst_bus_addr", bus_addr, 32'h0);
    check("midrst_mem_rdata", mem_rdata, 32'h0);
    check("midrst_if_rdata", if_rdata, 32'h0);
    $display("instr midrst: reset asserted during data wait");
    @(posedge clock);
    #1;
    reset = 1'b1;
    exp_err       = 1'b0;
    exp_mem_rdata = 32'h0;
    exp_if_rdata  = 32'h0;
    in_txn        = 1'b0;
    exp_q.delete();
    run_instr(1, 32'h40, 32'h0, 1'b0, 32'h0, 0, 0, "rst_restart");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
